// File: rtl/updi_txn_sequencer.sv
// updi_txn_sequencer: runs one UPDI transaction as TX -> ACK -> RX phases.
// Optional watchdog per wait phase enabled by `define UPDI_TXN_TIMEOUT_EN.
module updi_txn_sequencer #(
  parameter int BITS_N         = 6,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [BITS_N-1:0] cmd_tx_len,
  input  logic              cmd_ack,
  input  logic [BITS_N-1:0] cmd_rx_len,
  output logic              tx_start,
  output logic [BITS_N-1:0] tx_n_bytes,
  input  logic              tx_ready,
  output logic              rx_start,
  output logic              rx_wait_ack,
  output logic [BITS_N-1:0] rx_n_bytes,
  input  logic              rx_ready,
  input  logic              ack_received,
  output logic              handler_rst,
  output logic              done,
  output logic [1:0]        status
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TXS  = 3'd1;
  localparam logic [2:0] S_TXW  = 3'd2;
  localparam logic [2:0] S_ACKS = 3'd3;
  localparam logic [2:0] S_ACKW = 3'd4;
  localparam logic [2:0] S_RXS  = 3'd5;
  localparam logic [2:0] S_RXW  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_NACK = 2'd1;
  localparam logic [1:0] ST_TO   = 2'd2;

  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [BITS_N-1:0] tx_len_q, tx_len_d;
  logic [BITS_N-1:0] rx_len_q, rx_len_d;
  logic              ack_q, ack_d;
  logic              ack_seen_q, ack_seen_d;
  logic [1:0]        status_q, status_d;
  logic              phase_rdy;
  logic              to_fire;
  logic [2:0]        after_tx;
  logic [2:0]        after_ack;

  // Ready of the handler owning the current wait phase
  always_comb begin
    phase_rdy = 1'b0;
    if (state_q == S_TXW) phase_rdy = tx_ready;
    if (state_q == S_ACKW || state_q == S_RXW)
      phase_rdy = rx_ready;
  end

`ifdef UPDI_TXN_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 in_wait;

  assign in_wait = (state_q == S_TXW) ||
                   (state_q == S_ACKW) ||
                   (state_q == S_RXW);

  // Handler completion wins over an expiry in the same cycle
  assign to_fire = in_wait && (cnt_q == TO_LAST) && !phase_rdy;

  // Watchdog restarts at zero on every wait-state entry
  always_comb begin
    cnt_d = '0;
    if (in_wait) cnt_d = cnt_q + 1'b1;
  end

  // Watchdog register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic cfg_unused;
  assign cfg_unused = ^TO_LAST;
  assign to_fire    = 1'b0;
`endif

  assign after_ack = (rx_len_q != '0) ? S_RXS : S_DONE;
  assign after_tx  = ack_q ? S_ACKS : after_ack;

  // Phase sequencing and descriptor capture
  always_comb begin
    state_d    = state_q;
    tx_len_d   = tx_len_q;
    rx_len_d   = rx_len_q;
    ack_d      = ack_q;
    ack_seen_d = ack_seen_q;
    status_d   = status_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          tx_len_d = cmd_tx_len;
          rx_len_d = cmd_rx_len;
          ack_d    = cmd_ack;
          status_d = ST_OK;
          if (cmd_tx_len != '0)      state_d = S_TXS;
          else if (cmd_ack)          state_d = S_ACKS;
          else if (cmd_rx_len != '0) state_d = S_RXS;
          else                       state_d = S_DONE;
        end
      end
      S_TXS: state_d = S_TXW;
      S_TXW: begin
        if (tx_ready) begin
          state_d = after_tx;
        end else if (to_fire) begin
          status_d = ST_TO;
          state_d  = S_DONE;
        end
      end
      S_ACKS: begin
        ack_seen_d = 1'b0;
        state_d    = S_ACKW;
      end
      S_ACKW: begin
        if (ack_received) ack_seen_d = 1'b1;
        if (rx_ready) begin
          if (ack_seen_q || ack_received) begin
            state_d = after_ack;
          end else begin
            status_d = ST_NACK;
            state_d  = S_DONE;
          end
        end else if (to_fire) begin
          status_d = ST_TO;
          state_d  = S_DONE;
        end
      end
      S_RXS: state_d = S_RXW;
      S_RXW: begin
        if (rx_ready) begin
          state_d = S_DONE;
        end else if (to_fire) begin
          status_d = ST_TO;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and descriptor registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_len_q   <= '0;
      rx_len_q   <= '0;
      ack_q      <= 1'b0;
      ack_seen_q <= 1'b0;
      status_q   <= ST_OK;
    end else begin
      state_q    <= state_d;
      tx_len_q   <= tx_len_d;
      rx_len_q   <= rx_len_d;
      ack_q      <= ack_d;
      ack_seen_q <= ack_seen_d;
      status_q   <= status_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && tx_ready && rx_ready;
  assign tx_start    = (state_q == S_TXS);
  assign rx_wait_ack = (state_q == S_ACKS);
  assign rx_start    = (state_q == S_RXS);
  assign done        = (state_q == S_DONE);
  assign handler_rst = to_fire;
  assign tx_n_bytes  = tx_len_q;
  assign rx_n_bytes  = rx_len_q;
  assign status      = status_q;

endmodule

// File: tb/tb_updi_txn_sequencer.sv
// tb_updi_txn_sequencer: vector table plus scoreboard for the sequencer.
// Timeout vector runs only when UPDI_TXN_TIMEOUT_EN is defined.
module tb_updi_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_ack;
  logic [5:0] cmd_tx_len, cmd_rx_len;
  logic       tx_start, tx_ready;
  logic [5:0] tx_n_bytes, rx_n_bytes;
  logic       rx_start, rx_wait_ack, rx_ready;
  logic       ack_received, handler_rst, done;
  logic [1:0] status;

  always #5 clk = ~clk;

  updi_txn_sequencer #(
    .BITS_N(6), .TIMEOUT_W(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tx_len(cmd_tx_len), .cmd_ack(cmd_ack),
    .cmd_rx_len(cmd_rx_len),
    .tx_start(tx_start), .tx_n_bytes(tx_n_bytes),
    .tx_ready(tx_ready),
    .rx_start(rx_start), .rx_wait_ack(rx_wait_ack),
    .rx_n_bytes(rx_n_bytes), .rx_ready(rx_ready),
    .ack_received(ack_received),
    .handler_rst(handler_rst),
    .done(done), .status(status)
  );

  // Handler model knobs
  int tx_busy  = 1;
  int ack_busy = 2;
  int rx_busy  = 2;
  bit ack_ok   = 1'b0;
  bit ack_same = 1'b0;
  bit rx_stuck = 1'b0;

  int tx_cnt;
  always @(posedge clk) begin
    if (rst || handler_rst) begin
      tx_ready <= 1'b1;
      tx_cnt   <= 0;
    end else if (tx_start) begin
      tx_ready <= 1'b0;
      tx_cnt   <= tx_busy;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_ready <= 1'b1;
    end
  end

  int rx_cnt;
  bit rx_ackmode;
  always @(posedge clk) begin
    ack_received <= 1'b0;
    if (rst || handler_rst) begin
      rx_ready <= 1'b1;
      rx_cnt   <= 0;
    end else if (rx_wait_ack || rx_start) begin
      rx_ready   <= 1'b0;
      rx_ackmode <= rx_wait_ack;
      if (rx_wait_ack)   rx_cnt <= ack_busy;
      else if (rx_stuck) rx_cnt <= -1;
      else               rx_cnt <= rx_busy;
    end else if (rx_cnt > 0) begin
      rx_cnt <= rx_cnt - 1;
      if (rx_cnt == 1) rx_ready <= 1'b1;
      if (rx_ackmode && ack_ok &&
          rx_cnt == (ack_same ? 1 : 2))
        ack_received <= 1'b1;
    end
  end

  typedef struct {
    logic [5:0] tx;
    logic       ack;
    logic [5:0] rx;
    int         tb, ab, rb;
    bit         ok, same, stuck;
    logic [1:0] st;
    logic [7:0] ord;
    int         lat;
    int         hrst;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic [7:0] ord;
    int         lat;
    int         hrst;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  vec_t tov;
  int   nerr = 0;
  int   nchk = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t       e;
    logic [7:0] ord;
    int         hr, lat, w, npl;
    bit         got;
    tx_busy  = v.tb;
    ack_busy = v.ab;
    rx_busy  = v.rb;
    ack_ok   = v.ok;
    ack_same = v.same;
    rx_stuck = v.stuck;
    w = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (cmd_ready !== 1'b1) begin
      check({tag, "_ready"}, cmd_ready, 1);
      return;
    end
    cmd_valid  = 1'b1;
    cmd_tx_len = v.tx;
    cmd_ack    = v.ack;
    cmd_rx_len = v.rx;
    @(posedge clk);
    sb.push_back('{v.st, v.ord, v.lat, v.hrst});
    #1;
    cmd_valid  = 1'b0;
    cmd_tx_len = 6'($urandom);
    cmd_ack    = 1'($urandom);
    cmd_rx_len = 6'($urandom);
    ord = 8'd0;
    hr  = 0;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      npl = int'(tx_start) + int'(rx_start) + int'(rx_wait_ack);
      if (npl != 0) check({tag, "_excl"}, npl, 1);
      if (tx_start) begin
        ord = ord * 4 + 1;
        check({tag, "_txn"}, tx_n_bytes, v.tx);
      end
      if (rx_wait_ack) ord = ord * 4 + 2;
      if (rx_start) begin
        ord = ord * 4 + 3;
        check({tag, "_rxn"}, rx_n_bytes, v.rx);
      end
      if (handler_rst) hr++;
      if (done) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    check({tag, "_done_seen"}, got, 1);
    e = sb.pop_front();
    if (!got) return;
    check({tag, "_status"}, status, e.st);
    check({tag, "_order"}, ord, e.ord);
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_hrst"}, hr, e.hrst);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done, 0);
    repeat (2) @(negedge clk);
    check({tag, "_status_held"}, status, e.st);
    check({tag, "_idle_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nd;
    vecs[0] = '{6'd3,  1'b0, 6'd0,  5, 2, 2, 0, 0, 0,
                2'd0, 8'd1,  8,  0};
    vecs[1] = '{6'd2,  1'b1, 6'd4,  3, 3, 4, 1, 0, 0,
                2'd0, 8'd27, 17, 0};
    vecs[2] = '{6'd2,  1'b1, 6'd4,  3, 3, 4, 0, 0, 0,
                2'd1, 8'd6,  11, 0};
    vecs[3] = '{6'd0,  1'b0, 6'd0,  1, 2, 2, 0, 0, 0,
                2'd0, 8'd0,  1,  0};
    vecs[4] = '{6'd0,  1'b1, 6'd0,  1, 2, 2, 1, 1, 0,
                2'd0, 8'd2,  5,  0};
    vecs[5] = '{6'd0,  1'b0, 6'd5,  1, 2, 1, 0, 0, 0,
                2'd0, 8'd3,  4,  0};
    vecs[6] = '{6'd63, 1'b0, 6'd63, 1, 2, 2, 0, 0, 0,
                2'd0, 8'd7,  8,  0};
    vecs[7] = '{6'd1,  1'b1, 6'd0,  1, 4, 2, 0, 0, 0,
                2'd1, 8'd6,  10, 0};
    tov     = '{6'd0,  1'b0, 6'd3,  1, 2, 2, 0, 0, 1,
                2'd2, 8'd3,  18, 1};

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_tx_len = '0;
    cmd_ack    = 1'b0;
    cmd_rx_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_pulses",
          {tx_start, rx_start, rx_wait_ack, handler_rst, done}, 0);
    check("rst_status", status, 0);
    check("rst_lens", {tx_n_bytes, rx_n_bytes}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while TX handler is busy
    tx_busy = 10;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_tx_len = 6'd4;
    cmd_ack    = 1'b0;
    cmd_rx_len = 6'd0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy", tx_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_pulses",
          {tx_start, rx_start, rx_wait_ack, handler_rst, done}, 0);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_status", status, 0);
    check("midrst_txn", tx_n_bytes, 0);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midrst_no_done", nd, 0);
    run_vec(vecs[1], "after_rst");

`ifdef UPDI_TXN_TIMEOUT_EN
    run_vec(tov, "timeout");
    run_vec(vecs[0], "after_to");
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
